if_id_queue: RTL and testbench

//  Parametrised IF->ID decoupling stage: DEPTH-entry FIFO of {pc, inst} pairs.
//  - Replaces the single-register IF/ID latch; absorbs fetch/decode rate mismatch.
//  - valid/ready handshakes on both sides; ID-side stall; whole-queue flush on jump.
//  - Sits between the instruction-fetch/memory interface and the decoder.

---
 rtl/if_id_queue_if.sv | 29 ++
 rtl/if_id_queue.sv | 136 +++++++++++++
 tb/tb_if_id_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// IF->ID queue handshake bundle: fetch-side push channel, decode-side head channel, flush.
interface if_id_queue_if #(
  parameter int unsigned XLEN = 32
);
  // Fetch side
  logic            if_valid_i;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_inst_i;
  logic            if_ready_o;
  // Decode side
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [31:0]     id_inst_o;
  logic            id_stall_i;
  // Control flow redirect
  logic            jump_i;

  // Environment view: drives fetch data, stall and jump; observes the queue outputs.
  modport master (
    output if_valid_i, if_pc_i, if_inst_i, id_stall_i, jump_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_inst_o
  );

  // Queue view.
  modport slave (
    input  if_valid_i, if_pc_i, if_inst_i, id_stall_i, jump_i,
    output if_ready_o, id_valid_o, id_pc_o, id_inst_o
  );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO of {pc, inst} with valid/ready on both
// sides, decode stall and whole-queue flush on jump. All queue outputs are registered;
// the head registers are loaded from next-state values so decode sees a new entry
// one cycle after it is pushed into an empty queue.
module if_id_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] BUBBLE_INST = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  if_id_queue_if.slave                   q,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [15:0]                    flush_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned FCNT_W = 16;

  // Storage (never reset; only entries below count are ever presented)
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  // State
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [FCNT_W-1:0] flush_cnt;
  logic              if_ready_q;
  logic              id_valid_q;
  logic [XLEN-1:0]   id_pc_q;
  logic [31:0]       id_inst_q;

  // Next-state
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [FCNT_W-1:0] flush_cnt_nxt;
  logic [XLEN-1:0]   head_pc_nxt;
  logic [31:0]       head_inst_nxt;

  // Handshake qualification; a jump cancels both sides in the same cycle.
  always_comb begin
    push = q.if_valid_i & if_ready_q & ~q.jump_i;
    pop  = id_valid_q & ~q.id_stall_i & ~q.jump_i;
  end

  // Pointer, occupancy and flush-counter next state.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    flush_cnt_nxt = flush_cnt;
    if (q.jump_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      if ((count != '0) && (flush_cnt != {FCNT_W{1'b1}})) begin
        flush_cnt_nxt = flush_cnt + FCNT_W'(1);
      end
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Next head entry: the slot being written this cycle only becomes the head when
  // the queue drains to empty before the push, so forward the incoming pair then.
  always_comb begin
    head_pc_nxt   = '0;
    head_inst_nxt = BUBBLE_INST;
    if (count_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        head_pc_nxt   = q.if_pc_i;
        head_inst_nxt = q.if_inst_i;
      end else begin
        head_pc_nxt   = pc_mem[rd_ptr_nxt];
        head_inst_nxt = inst_mem[rd_ptr_nxt];
      end
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]   <= q.if_pc_i;
      inst_mem[wr_ptr] <= q.if_inst_i;
    end
  end

  // Control state and registered outputs; reset wins over jump and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_cnt  <= '0;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= BUBBLE_INST;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      flush_cnt  <= flush_cnt_nxt;
      if_ready_q <= (count_nxt != CNT_W'(DEPTH));
      id_valid_q <= (count_nxt != '0);
      id_pc_q    <= head_pc_nxt;
      id_inst_q  <= head_inst_nxt;
    end
  end

  // Output drive.
  always_comb begin
    q.if_ready_o = if_ready_q;
    q.id_valid_o = id_valid_q;
    q.id_pc_o    = id_pc_q;
    q.id_inst_o  = id_inst_q;
    count_o      = count;
    flush_cnt_o  = flush_cnt;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised scoreboard bench for if_id_queue: the driver records accepted
// instructions in an expected-order queue, a negedge monitor compares the decode
// head and status outputs against it and retires entries as decode consumes them.
module tb_if_id_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BUBBLE = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [2:0]  count_o;
  logic [15:0] flush_cnt_o;

  if_id_queue_if #(.XLEN(XLEN)) bus ();

  if_id_queue #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q(bus),
    .count_o(count_o),
    .flush_cnt_o(flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;
  logic [15:0] exp_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1 with
  // the reference queue updated to the contents the DUT should now hold.
  task automatic cycle(input logic v, input logic st, input logic j, input logic r);
    logic acc;
    bus.if_valid_i = v;
    bus.if_pc_i    = cur_pc;
    bus.if_inst_i  = cur_inst;
    bus.id_stall_i = st;
    bus.jump_i     = j;
    rst            = r;
    acc = !r && !j && v && (sb.size() < DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      exp_flush = 16'h0;
    end else if (j) begin
      if (sb.size() != 0 && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'h1;
      sb.delete();
      cur_pc   = $urandom & 32'hFFFF_FFFC;
      cur_inst = $urandom;
    end else if (acc) begin
      sb.push_back('{pc: cur_pc, inst: cur_inst});
      cur_pc   = cur_pc + 32'h4;
      cur_inst = $urandom;
    end
  endtask

  // Monitor: compare presented state against the reference, retire consumed heads.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count_o), 32'(sb.size()));
      chk("if_ready", 32'(bus.if_ready_o), 32'(sb.size() != DEPTH));
      chk("id_valid", 32'(bus.id_valid_o), 32'(sb.size() != 0));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(exp_flush));
      if (sb.size() != 0) begin
        chk("head_pc", bus.id_pc_o, sb[0].pc);
        chk("head_inst", bus.id_inst_o, sb[0].inst);
        if (!bus.id_stall_i && !bus.jump_i && !rst) void'(sb.pop_front());
      end else begin
        chk("bubble_pc", bus.id_pc_o, 32'h0);
        chk("bubble_inst", bus.id_inst_o, BUBBLE);
      end
    end
  end

  initial begin
    cur_pc         = 32'h0;
    cur_inst       = $urandom;
    exp_flush      = 16'h0;
    rst            = 1'b1;
    bus.if_valid_i = 1'b0;
    bus.if_pc_i    = '0;
    bus.if_inst_i  = '0;
    bus.id_stall_i = 1'b0;
    bus.jump_i     = 1'b0;

    // Reset for two cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid_o), 32'h0);
    chk("rst_id_inst", bus.id_inst_o, 32'h0);
    chk("rst_id_pc", bus.id_pc_o, 32'h0);
    chk("rst_if_ready", 32'(bus.if_ready_o), 32'h1);
    chk("rst_flush_cnt", 32'(flush_cnt_o), 32'h0);
    mon_en = 1'b1;

    // Two back-to-back pushes, no stall
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", 32'(bus.id_valid_o), 32'h1);
    chk("lat_pc0", bus.id_pc_o, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_pc4", bus.id_pc_o, 32'h4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Fill while stalled; fifth instruction must be held
    cur_pc = 32'h0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(count_o), 32'(DEPTH));
    chk("full_ready", 32'(bus.if_ready_o), 32'h0);
    chk("full_held_pc", cur_pc, 32'h10);
    // Full + pop + valid: push rejected, count drops to DEPTH-1
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_pop_count", 32'(count_o), 32'(DEPTH - 1));
    chk("full_pop_head", bus.id_pc_o, 32'h4);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Three entries then jump with a valid fetch
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_jump_count", 32'(count_o), 32'h3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("jump_count", 32'(count_o), 32'h0);
    chk("jump_valid", 32'(bus.id_valid_o), 32'h0);
    chk("jump_flush_cnt", 32'(flush_cnt_o), 32'h1);
    // Jump on empty queue does not count
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_jump_flush_cnt", 32'(flush_cnt_o), 32'h1);
    // Push after flush accepted normally
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_valid", 32'(bus.id_valid_o), 32'h1);
    // Reset beats jump
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_over_jump_flush", 32'(flush_cnt_o), 32'h0);
    chk("rst_over_jump_count", 32'(count_o), 32'h0);

    // Random traffic with stalls, jumps and rare resets
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 500) == 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
